// File: rtl/vga_pkg.sv
// Shared 640x400 VGA timing constants, text-mode geometry and VRAM slot map.
package vga_pkg;

    localparam int unsigned HZV = 640;
    localparam int unsigned HZF = 16;
    localparam int unsigned HZS = 96;
    localparam int unsigned HZB = 48;
    localparam int unsigned HZW = 800;

    localparam int unsigned VTV = 400;
    localparam int unsigned VTF = 12;
    localparam int unsigned VTS = 2;
    localparam int unsigned VTB = 35;
    localparam int unsigned VTW = 449;

    localparam int unsigned COLS      = 80;
    localparam int unsigned ROWS      = 25;
    localparam logic [15:0] FONT_BASE = 16'h1000;

    localparam logic [2:0] SLOT_CHR = 3'd0;
    localparam logic [2:0] SLOT_ATR = 3'd1;
    localparam logic [2:0] SLOT_FNT = 3'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } cpu_state_e;

endpackage

// File: rtl/vram_cpu_port.sv
// CPU access FSM plus the registered VRAM address/data mux shared with display fetches.
module vram_cpu_port
    import vga_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic        i_slot_free,
    input  logic        i_fetch_valid,
    input  logic [15:0] i_fetch_addr,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata
);

    cpu_state_e  r_state;
    cpu_state_e  w_state_next;
    logic        w_grant;
    logic [15:0] r_mem_addr;
    logic        r_mem_we;
    logic [7:0]  r_mem_wdata;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The ACK cycle never grants, which spaces CPU accesses at least two cycles apart.
    always_comb begin
        w_grant     = (r_state == ST_IDLE) && i_cpu_req && i_slot_free;
        o_cpu_ack   = (r_state == ST_ACK);
        o_cpu_rdata = (r_state == ST_ACK) ? i_mem_rdata : 8'd0;
    end

    // Display fetch and CPU grant never share a slot; idle slots keep the last address.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_mem_addr  <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'd0;
        end else if (i_fetch_valid) begin
            r_mem_addr <= i_fetch_addr;
            r_mem_we   <= 1'b0;
        end else if (w_grant) begin
            r_mem_addr  <= i_cpu_addr;
            r_mem_we    <= i_cpu_we;
            r_mem_wdata <= i_cpu_wdata;
        end else begin
            r_mem_we <= 1'b0;
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: rtl/vram_sched.sv
// VRAM time-slot scheduler: char/attr/font fetches in slots 0..2 of every 8-clock
// cell inside the fetch window, all other slots handed to the CPU port.
module vram_sched #(
    parameter int unsigned HZB       = vga_pkg::HZB,
    parameter int unsigned VTB       = vga_pkg::VTB,
    parameter int unsigned COLS      = vga_pkg::COLS,
    parameter int unsigned ROWS      = vga_pkg::ROWS,
    parameter logic [15:0] FONT_BASE = vga_pkg::FONT_BASE
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_WDATA,
    output logic        CPU_ACK,
    output logic [7:0]  CPU_RDATA,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    output logic [7:0]  CHAR_CODE,
    output logic [7:0]  ATTR,
    output logic [7:0]  FONT_BITS,
    output logic        LOAD
);
    import vga_pkg::*;

    localparam logic [9:0] FX_LO = 10'(HZB - 8);
    localparam logic [9:0] FX_HI = 10'(HZB + 8 * COLS - 8);
    localparam logic [9:0] LX_LO = 10'(HZB);
    localparam logic [9:0] LX_HI = 10'(HZB + 8 * COLS);
    localparam logic [9:0] FY_LO = 10'(VTB);
    localparam logic [9:0] FY_HI = 10'(VTB + 16 * ROWS);

    logic [2:0]      w_slot;
    logic [6:0]      w_col;
    logic [9:0]      w_yoff;
    logic [5:0]      w_row;
    logic [3:0]      w_line;
    logic            w_row_act;
    logic            w_fetch_win;
    logic            w_load;
    logic            w_slot_free;
    logic            w_fetch_valid;
    logic [15:0]     w_cell;
    logic [15:0]     w_text_addr;
    logic [15:0]     w_font_addr;
    logic [15:0]     w_fetch_addr;
    logic [2:0][7:0] w_next;
    logic [2:0][7:0] w_disp;
    logic            r_load;

    // Fetch window runs one cell ahead of the visible area.
    assign w_slot      = X[2:0];
    assign w_col       = 7'((X - FX_LO) >> 3);
    assign w_yoff      = Y - FY_LO;
    assign w_row       = w_yoff[9:4];
    assign w_line      = w_yoff[3:0];
    assign w_row_act   = (Y >= FY_LO) && (Y < FY_HI);
    assign w_fetch_win = w_row_act && (X >= FX_LO) && (X < FX_HI);
    assign w_load      = w_row_act && (X >= LX_LO) && (X < LX_HI) && (w_slot == SLOT_CHR);
    assign w_slot_free = !(w_fetch_win && (w_slot <= SLOT_FNT));

    assign w_cell      = 16'(w_row) * 16'(COLS) + 16'(w_col);
    assign w_text_addr = {w_cell[14:0], 1'b0};
    assign w_font_addr = FONT_BASE + {4'd0, w_next[0], 4'd0} + {12'd0, w_line};

    always_comb begin
        w_fetch_valid = 1'b0;
        w_fetch_addr  = w_text_addr;
        if (w_fetch_win) begin
            case (w_slot)
                SLOT_CHR: w_fetch_valid = 1'b1;
                SLOT_ATR: begin
                    w_fetch_valid = 1'b1;
                    w_fetch_addr  = w_text_addr | 16'd1;
                end
                SLOT_FNT: begin
                    w_fetch_valid = 1'b1;
                    w_fetch_addr  = w_font_addr;
                end
                default: ;
            endcase
        end
    end

    // Byte gi (char, attr, font) returns from RAM one slot after its address slot.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_byte
            logic [7:0] r_next;
            logic [7:0] r_disp;

            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    r_next <= 8'd0;
                    r_disp <= 8'd0;
                end else begin
                    if (w_fetch_win && (w_slot == 3'(int'(SLOT_ATR) + gi))) r_next <= MEM_RDATA;
                    if (w_load) r_disp <= r_next;
                end
            end

            assign w_next[gi] = r_next;
            assign w_disp[gi] = r_disp;
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_load <= 1'b0;
        end else begin
            r_load <= w_load;
        end
    end

    assign CHAR_CODE = w_disp[0];
    assign ATTR      = w_disp[1];
    assign FONT_BITS = w_disp[2];
    assign LOAD      = r_load;

    vram_cpu_port u_cpu_port (
        .i_clk         (CLOCK),
        .i_srst        (RESET),
        .i_slot_free   (w_slot_free),
        .i_fetch_valid (w_fetch_valid),
        .i_fetch_addr  (w_fetch_addr),
        .i_cpu_req     (CPU_REQ),
        .i_cpu_we      (CPU_WE),
        .i_cpu_addr    (CPU_ADDR),
        .i_cpu_wdata   (CPU_WDATA),
        .i_mem_rdata   (MEM_RDATA),
        .o_cpu_ack     (CPU_ACK),
        .o_cpu_rdata   (CPU_RDATA),
        .o_mem_addr    (MEM_ADDR),
        .o_mem_we      (MEM_WE),
        .o_mem_wdata   (MEM_WDATA)
    );

endmodule

// File: tb/tb_vram_sched.sv
// Scoreboard bench for vram_sched: beam lines are driven directly, expectations are
// queued with their due cycle and compared at the negedge of that cycle.
module tb_vram_sched;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_WDATA;
    logic        CPU_ACK;
    logic [7:0]  CPU_RDATA;
    logic [15:0] MEM_ADDR;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic [7:0]  CHAR_CODE;
    logic [7:0]  ATTR;
    logic [7:0]  FONT_BITS;
    logic        LOAD;

    localparam int F_ADDR  = 0;
    localparam int F_WE    = 1;
    localparam int F_WDATA = 2;
    localparam int F_ACK   = 3;
    localparam int F_RDATA = 4;
    localparam int F_LOAD  = 5;
    localparam int F_CHAR  = 6;
    localparam int F_ATTR  = 7;
    localparam int F_FONT  = 8;

    int n_checks = 0;
    int n_errors = 0;
    int now      = 0;
    int we_cnt   = 0;
    int load_cnt = 0;
    int ack_win  = 0;
    bit hold_req = 1'b0;

    int          q_at[$];
    int          q_fld[$];
    logic [31:0] q_val[$];
    string       q_tag[$];

    logic [7:0] vram [0:65535];

    always #5 CLOCK = ~CLOCK;

    assign MEM_RDATA = vram[MEM_ADDR];
    always @(posedge CLOCK) if (MEM_WE === 1'b1) vram[MEM_ADDR] <= MEM_WDATA;

    vram_sched dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .X         (X),
        .Y         (Y),
        .CPU_REQ   (CPU_REQ),
        .CPU_WE    (CPU_WE),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_WDATA (CPU_WDATA),
        .CPU_ACK   (CPU_ACK),
        .CPU_RDATA (CPU_RDATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WE    (MEM_WE),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .CHAR_CODE (CHAR_CODE),
        .ATTR      (ATTR),
        .FONT_BITS (FONT_BITS),
        .LOAD      (LOAD)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, now);
        end
    endtask

    function automatic logic [31:0] observe(input int f);
        case (f)
            F_ADDR:  return {16'd0, MEM_ADDR};
            F_WE:    return {31'd0, MEM_WE};
            F_WDATA: return {24'd0, MEM_WDATA};
            F_ACK:   return {31'd0, CPU_ACK};
            F_RDATA: return {24'd0, CPU_RDATA};
            F_LOAD:  return {31'd0, LOAD};
            F_CHAR:  return {24'd0, CHAR_CODE};
            F_ATTR:  return {24'd0, ATTR};
            F_FONT:  return {24'd0, FONT_BITS};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp_at(input int dly, input string tag, input int fld, input logic [31:0] val);
        q_at.push_back(now + dly);
        q_tag.push_back(tag);
        q_fld.push_back(fld);
        q_val.push_back(val);
    endtask

    // Scoreboard: pop every expectation due in this cycle.
    always @(negedge CLOCK) begin
        if (RESET === 1'b0) begin
            if (MEM_WE === 1'b1) we_cnt++;
            if (LOAD === 1'b1) load_cnt++;
        end
        for (int i = q_at.size() - 1; i >= 0; i--) begin
            if (q_at[i] <= now) begin
                check_eq(q_tag[i], observe(q_fld[i]), q_val[i]);
                q_at.delete(i);
                q_tag.delete(i);
                q_fld.delete(i);
                q_val.delete(i);
            end
        end
    end

    // One clock; the CPU agent drops REQ in its ACK cycle unless told to hold it.
    task automatic cyc();
        @(posedge CLOCK);
        now++;
        #1;
        if (CPU_ACK === 1'b1) begin
            $display("cpu %s addr=0x%04h data=0x%02h t=%0d", CPU_WE ? "wr" : "rd",
                     CPU_ADDR, CPU_WE ? CPU_WDATA : CPU_RDATA, now);
            if (!hold_req) CPU_REQ = 1'b0;
        end
    endtask

    task automatic cpu_issue(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        CPU_REQ   = 1'b1;
        CPU_WE    = we;
        CPU_ADDR  = addr;
        CPU_WDATA = wdata;
    endtask

    task automatic stim(input int y, input int x);
        if (y == 35) begin
            case (x)
                40: exp_at(1, "fetch_chr_addr", F_ADDR, 32'd0);
                41: begin
                    exp_at(1, "fetch_atr_addr", F_ADDR, 32'd1);
                    cpu_issue(1'b1, 16'h0002, 8'h5A);
                    exp_at(1, "wr_wait_slot1", F_ACK, 32'd0);
                    exp_at(2, "wr_wait_slot2", F_ACK, 32'd0);
                    exp_at(3, "wr_addr", F_ADDR, 32'h0002);
                    exp_at(3, "wr_we", F_WE, 32'd1);
                    exp_at(3, "wr_wdata", F_WDATA, 32'h5A);
                    exp_at(3, "wr_ack", F_ACK, 32'd1);
                    exp_at(4, "wr_we_drop", F_WE, 32'd0);
                end
                42: exp_at(1, "fetch_fnt_addr", F_ADDR, 32'h1410);
                47: begin
                    cpu_issue(1'b0, 16'h0100, 8'h00);
                    exp_at(1, "rd_slot7_ack", F_ACK, 32'd1);
                    exp_at(1, "rd_slot7_data", F_RDATA, 32'hC3);
                end
                48: begin
                    exp_at(1, "c0_load", F_LOAD, 32'd1);
                    exp_at(1, "c0_char", F_CHAR, 32'h41);
                    exp_at(1, "c0_attr", F_ATTR, 32'h1F);
                    exp_at(1, "c0_font", F_FONT, 32'h18);
                    exp_at(1, "c1_fetch_addr", F_ADDR, 32'h0002);
                    exp_at(2, "c0_load_pulse", F_LOAD, 32'd0);
                end
                56: begin
                    exp_at(1, "c1_char", F_CHAR, 32'h5A);
                    exp_at(1, "c1_attr", F_ATTR, 32'h2E);
                    exp_at(1, "c1_font", F_FONT, 32'h7E);
                end
                100: begin
                    cpu_issue(1'b0, 16'h0002, 8'h00);
                    exp_at(1, "rdback_ack", F_ACK, 32'd1);
                    exp_at(1, "rdback_data", F_RDATA, 32'h5A);
                end
                default: ;
            endcase
        end else if (y == 434) begin
            case (x)
                672: exp_at(1, "last_chr_addr", F_ADDR, 32'd3998);
                673: exp_at(1, "last_atr_addr", F_ADDR, 32'd3999);
                674: exp_at(1, "last_fnt_addr", F_ADDR, 32'h133F);
                680: begin
                    exp_at(1, "c79_load", F_LOAD, 32'd1);
                    exp_at(1, "c79_char", F_CHAR, 32'h33);
                    exp_at(1, "c79_attr", F_ATTR, 32'h07);
                    exp_at(1, "c79_font", F_FONT, 32'hA5);
                end
                687: exp_at(1, "no_fetch_tail", F_ADDR, 32'h133F);
                688: exp_at(1, "no_load_past_end", F_LOAD, 32'd0);
                default: ;
            endcase
        end else if (y == 440) begin
            if (x == 16) begin
                hold_req = 1'b1;
                cpu_issue(1'b0, 16'h0100, 8'h00);
            end
            if (x >= 24 && x < 32 && CPU_ACK === 1'b1) ack_win++;
            if (x == 40) begin
                CPU_REQ  = 1'b0;
                hold_req = 1'b0;
            end
            if (x == 100) begin
                RESET = 1'b1;
                cpu_issue(1'b0, 16'h0100, 8'h00);
                exp_at(1, "rst_no_ack", F_ACK, 32'd0);
                exp_at(1, "rst_mem_addr", F_ADDR, 32'd0);
                exp_at(1, "rst_char", F_CHAR, 32'd0);
                exp_at(2, "rst_no_ack_late", F_ACK, 32'd0);
            end
            if (x == 101) begin
                RESET   = 1'b0;
                CPU_REQ = 1'b0;
            end
            if (x == 104) begin
                cpu_issue(1'b0, 16'h0100, 8'h00);
                exp_at(1, "rereq_ack", F_ACK, 32'd1);
                exp_at(1, "rereq_data", F_RDATA, 32'hC3);
            end
        end
    endtask

    task automatic run_line(input int y);
        we_cnt   = 0;
        load_cnt = 0;
        for (int x = 0; x < 800; x++) begin
            cyc();
            X = 10'(x);
            Y = 10'(y);
            stim(y, x);
        end
    endtask

    initial begin
        RESET     = 1'b1;
        X         = 10'd0;
        Y         = 10'd0;
        CPU_REQ   = 1'b0;
        CPU_WE    = 1'b0;
        CPU_ADDR  = 16'd0;
        CPU_WDATA = 8'd0;

        for (int i = 0; i < 65536; i++) vram[i] <= 8'h00;
        vram[16'h0000] <= 8'h41;
        vram[16'h0001] <= 8'h1F;
        vram[16'h0003] <= 8'h2E;
        vram[16'h0100] <= 8'hC3;
        vram[16'h1410] <= 8'h18;
        vram[16'h15A0] <= 8'h7E;
        vram[16'd3998] <= 8'h33;
        vram[16'd3999] <= 8'h07;
        vram[16'h133F] <= 8'hA5;

        repeat (3) cyc();
        RESET = 1'b0;
        cyc();
        check_eq("rst_cpu_ack", {31'd0, CPU_ACK}, 32'd0);
        check_eq("rst_cpu_rdata", {24'd0, CPU_RDATA}, 32'd0);
        check_eq("rst_mem_addr", {16'd0, MEM_ADDR}, 32'd0);
        check_eq("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        check_eq("rst_mem_wdata", {24'd0, MEM_WDATA}, 32'd0);
        check_eq("rst_char", {24'd0, CHAR_CODE}, 32'd0);
        check_eq("rst_attr", {24'd0, ATTR}, 32'd0);
        check_eq("rst_font", {24'd0, FONT_BITS}, 32'd0);
        check_eq("rst_load", {31'd0, LOAD}, 32'd0);

        run_line(0);
        check_eq("blank_we_count", we_cnt, 0);
        check_eq("blank_load_count", load_cnt, 0);

        run_line(35);
        check_eq("y35_we_count", we_cnt, 1);
        check_eq("y35_load_count", load_cnt, 80);

        run_line(434);
        check_eq("y434_we_count", we_cnt, 0);
        check_eq("y434_load_count", load_cnt, 80);

        run_line(440);
        check_eq("burst_acks_per_cell", ack_win, 4);
        check_eq("y440_we_count", we_cnt, 0);
        check_eq("y440_load_count", load_cnt, 0);

        repeat (4) cyc();
        check_eq("scoreboard_drained", q_at.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
